ps2_wasd_decoder: RTL and testbench

//  PS/2 keyboard front end feeding the Blocky movement FSM.
//  - Receives device-to-host PS/2 frames and decodes make/break scancodes.
//  - Outputs held-key levels for W/S/A/D, Enter (start) and Esc (restart) as clean, clk-synchronous signals.
//  - Multiple keys may be held at once; movement priority is resolved by the consumer FSM.

---
 rtl/ps2_pkg.sv | 45 ++++
 rtl/ps2_rx_frame.sv | 119 +++++++++++
 rtl/ps2_wasd_decoder.sv | 100 ++++++++++
 tb/tb_ps2_wasd_decoder.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 scancodes, key-bit positions and the frame-state encoding.
// Pure declarations; no timing or flow control of its own.
package ps2_pkg;

   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_ESC   = 8'h76;
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;

   localparam int NUM_KEYS    = 6;
   localparam int KEY_W       = 0;
   localparam int KEY_S       = 1;
   localparam int KEY_A       = 2;
   localparam int KEY_D       = 3;
   localparam int KEY_START   = 4;
   localparam int KEY_RESTART = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } frame_state_e;

   // One-hot key position for a make/break code; zero for unmapped codes.
   function automatic logic [NUM_KEYS-1:0] key_mask(input logic [7:0] code);
      logic [NUM_KEYS-1:0] m;
      m = '0;
      case (code)
         SC_W:     m[KEY_W]       = 1'b1;
         SC_S:     m[KEY_S]       = 1'b1;
         SC_A:     m[KEY_A]       = 1'b1;
         SC_D:     m[KEY_D]       = 1'b1;
         SC_ENTER: m[KEY_START]   = 1'b1;
         SC_ESC:   m[KEY_RESTART] = 1'b1;
         default:  m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: sync, edge detect, frame FSM, timeout, optional parity (PS2_PARITY_CHECK_EN).
// byte_vld/byte_err are single-cycle strobes in the cycle the stop edge (or timeout) is seen.
// No backpressure: the PS/2 device cannot be stalled, strobes must be consumed when raised.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [7:0] byte_dat,
   output logic       byte_vld,
   output logic       byte_err
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   // [0],[1] are the synchroniser; [2] is the previous synced value for edge detect.
   logic [2:0]   clk_sh_q, clk_sh_d;
   logic [1:0]   dat_sh_q, dat_sh_d;
   frame_state_e state_q, state_d;
   logic [2:0]   bit_cnt_q, bit_cnt_d;
   logic [7:0]   shift_q, shift_d;
   logic [CW-1:0] idle_cnt_q, idle_cnt_d;
`ifdef PS2_PARITY_CHECK_EN
   logic         par_q, par_d;
`endif

   logic fall;
   logic din;

   assign fall     = clk_sh_q[2] & ~clk_sh_q[1];
   assign din      = dat_sh_q[1];
   assign byte_dat = shift_q;

   always_comb begin
      clk_sh_d   = {clk_sh_q[1:0], ps2_clk};
      dat_sh_d   = {dat_sh_q[0], ps2_dat};
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      idle_cnt_d = idle_cnt_q;
`ifdef PS2_PARITY_CHECK_EN
      par_d      = par_q;
`endif
      byte_vld   = 1'b0;
      byte_err   = 1'b0;

      if (state_q == ST_IDLE) begin
         idle_cnt_d = '0;
         if (fall && !din) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
         end
      end else if (fall) begin
         idle_cnt_d = '0;
         case (state_q)
            ST_DATA: begin
               shift_d   = {din, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
            end
            ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
               par_d = din;
`endif
               state_d = ST_STOP;
            end
            default: begin
               state_d = ST_IDLE;
               if (!din) begin
                  byte_err = 1'b1;
               end else begin
`ifdef PS2_PARITY_CHECK_EN
                  if (^{shift_q, par_q}) byte_vld = 1'b1;
                  else                   byte_err = 1'b1;
`else
                  byte_vld = 1'b1;
`endif
               end
            end
         endcase
      end else if (idle_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
         // Device went quiet mid-frame: drop whatever was collected.
         byte_err   = 1'b1;
         state_d    = ST_IDLE;
         idle_cnt_d = '0;
      end else begin
         idle_cnt_d = idle_cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         clk_sh_q   <= 3'b111;
         dat_sh_q   <= 2'b11;
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'h00;
         idle_cnt_q <= '0;
`ifdef PS2_PARITY_CHECK_EN
         par_q      <= 1'b0;
`endif
      end else begin
         clk_sh_q   <= clk_sh_d;
         dat_sh_q   <= dat_sh_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         idle_cnt_q <= idle_cnt_d;
`ifdef PS2_PARITY_CHECK_EN
         par_q      <= par_d;
`endif
      end
   end

endmodule

// File: rtl/ps2_wasd_decoder.sv
// PS/2 keyboard front end: held-key levels for W/S/A/D/Enter/Esc (parity check under PS2_PARITY_CHECK_EN).
// scan_code/scan_valid/frame_err and key levels are registered one cycle after the stop edge.
// No backpressure: outputs are levels plus single-cycle pulses.
module ps2_wasd_decoder
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic       w_key,
   output logic       s_key,
   output logic       a_key,
   output logic       d_key,
   output logic       start_key,
   output logic       restart_key,
   output logic [7:0] scan_code,
   output logic       scan_valid,
   output logic       frame_err
);

   logic [7:0] rx_byte;
   logic       rx_vld;
   logic       rx_err;

   ps2_rx_frame #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_rx (
      .clk      (clk),
      .resetn   (resetn),
      .ps2_clk  (ps2_clk),
      .ps2_dat  (ps2_dat),
      .byte_dat (rx_byte),
      .byte_vld (rx_vld),
      .byte_err (rx_err)
   );

   logic                ext_q, ext_d;
   logic                brk_q, brk_d;
   logic [NUM_KEYS-1:0] keys_q, keys_d;
   logic [7:0]          scan_code_q, scan_code_d;
   logic                scan_valid_q, scan_valid_d;
   logic                frame_err_q, frame_err_d;
   logic [NUM_KEYS-1:0] mask;

   always_comb begin
      ext_d        = ext_q;
      brk_d        = brk_q;
      keys_d       = keys_q;
      scan_code_d  = scan_code_q;
      scan_valid_d = rx_vld;
      frame_err_d  = rx_err;
      mask         = key_mask(rx_byte);

      if (rx_vld) begin
         scan_code_d = rx_byte;
         if (rx_byte == SC_EXT) begin
            ext_d = 1'b1;
         end else if (rx_byte == SC_BREAK) begin
            brk_d = 1'b1;
         end else begin
            // Extended codes share make values with W/S/A/D (e.g. E0 1D), so they never touch keys.
            if (!ext_q) keys_d = brk_q ? (keys_q & ~mask) : (keys_q | mask);
            ext_d = 1'b0;
            brk_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ext_q        <= 1'b0;
         brk_q        <= 1'b0;
         keys_q       <= '0;
         scan_code_q  <= 8'h00;
         scan_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         ext_q        <= ext_d;
         brk_q        <= brk_d;
         keys_q       <= keys_d;
         scan_code_q  <= scan_code_d;
         scan_valid_q <= scan_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign w_key       = keys_q[KEY_W];
   assign s_key       = keys_q[KEY_S];
   assign a_key       = keys_q[KEY_A];
   assign d_key       = keys_q[KEY_D];
   assign start_key   = keys_q[KEY_START];
   assign restart_key = keys_q[KEY_RESTART];
   assign scan_code   = scan_code_q;
   assign scan_valid  = scan_valid_q;
   assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_wasd_decoder.sv
// Bench for ps2_wasd_decoder: bit-level PS/2 frames against a held-key reference model.
module tb_ps2_wasd_decoder;

   localparam int H   = 8;       // clk cycles per PS/2 clock half period
   localparam int TMO = 50000;
`ifdef PS2_PARITY_CHECK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       resetn;
   logic       ps2_clk;
   logic       ps2_dat;
   logic       w_key, s_key, a_key, d_key, start_key, restart_key;
   logic [7:0] scan_code;
   logic       scan_valid;
   logic       frame_err;

   always #5 clk = ~clk;

   ps2_wasd_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .ps2_clk     (ps2_clk),
      .ps2_dat     (ps2_dat),
      .w_key       (w_key),
      .s_key       (s_key),
      .a_key       (a_key),
      .d_key       (d_key),
      .start_key   (start_key),
      .restart_key (restart_key),
      .scan_code   (scan_code),
      .scan_valid  (scan_valid),
      .frame_err   (frame_err)
   );

   int vectors    = 0;
   int miscompares = 0;
   int vld_cnt    = 0;
   int err_cnt    = 0;

   // Reference model: which scancodes are currently held, plus prefix state.
   bit held [256];
   bit m_ext, m_brk;

   always @(negedge clk) begin
      if (resetn) begin
         if (scan_valid) vld_cnt++;
         if (frame_err)  err_cnt++;
      end
   end

   function automatic logic [5:0] exp_keys();
      return {held[8'h76], held[8'h5A], held[8'h23], held[8'h1C], held[8'h1B], held[8'h1D]};
   endfunction

   function automatic logic [5:0] dut_keys();
      return {restart_key, start_key, d_key, a_key, s_key, w_key};
   endfunction

   task automatic model_reset();
      foreach (held[i]) held[i] = 1'b0;
      m_ext = 1'b0;
      m_brk = 1'b0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (b == 8'hE0)      m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
         if (!m_ext) held[b] = !m_brk;
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   // All stimulus changes land 2 time units after a rising edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic ps2_bit(input logic v);
      ps2_dat = v;
      tick(H);
      ps2_clk = 1'b0;
      tick(H);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop_val);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit((~^b) ^ par_flip);
      ps2_bit(stop_val);
      tick(2);
   endtask

   task automatic send_good(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b1);
      model_byte(b);
   endtask

   task automatic test_reset();
      resetn  = 1'b0;
      ps2_clk = 1'b1;
      ps2_dat = 1'b1;
      model_reset();
      tick(5);
      vectors++;
      if (dut_keys() !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_keys: got %b expected %b", dut_keys(), 6'b0);
      end
      vectors++;
      if (scan_code !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_scan_code: got %h expected 00", scan_code);
      end
      vectors++;
      if ({scan_valid, frame_err} !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_pulses: got %b expected 00", {scan_valid, frame_err});
      end
      resetn = 1'b1;
      tick(5);
      vectors++;
      if (vld_cnt != 0 || err_cnt != 0) begin
         miscompares++;
         $display("FAIL reset_idle: vld=%0d err=%0d expected 0 0", vld_cnt, err_cnt);
      end
   endtask

   task automatic test_single_make();
      int v0 = vld_cnt;
      send_good(8'h1D);
      vectors++;
      if (vld_cnt - v0 != 1) begin
         miscompares++;
         $display("FAIL make_valid: pulses=%0d expected 1", vld_cnt - v0);
      end
      vectors++;
      if (scan_code !== 8'h1D) begin
         miscompares++;
         $display("FAIL make_code: got %h expected 1d", scan_code);
      end
      vectors++;
      if (dut_keys() !== exp_keys()) begin
         miscompares++;
         $display("FAIL make_keys: got %b expected %b", dut_keys(), exp_keys());
      end
   endtask

   task automatic test_make_break();
      int v0 = vld_cnt;
      int e0 = err_cnt;
      logic [7:0] seq [3];
      logic [2:0] w_exp;
      seq[0] = 8'h1D; seq[1] = 8'hF0; seq[2] = 8'h1D;
      w_exp = 3'b011;  // w_key after each byte, index 0 in bit 0
      for (int i = 0; i < 3; i++) begin
         send_good(seq[i]);
         vectors++;
         if (w_key !== w_exp[i] || dut_keys() !== exp_keys()) begin
            miscompares++;
            $display("FAIL make_break_step%0d: keys=%b expected %b", i, dut_keys(), exp_keys());
         end
      end
      vectors++;
      if (vld_cnt - v0 != 3 || err_cnt != e0) begin
         miscompares++;
         $display("FAIL make_break_counts: vld=%0d err=%0d expected 3 0", vld_cnt - v0, err_cnt - e0);
      end
   endtask

   task automatic test_multi_key();
      send_good(8'h1D);
      send_good(8'h23);
      vectors++;
      if ({w_key, d_key} !== 2'b11 || dut_keys() !== exp_keys()) begin
         miscompares++;
         $display("FAIL multi_hold: keys=%b expected %b", dut_keys(), exp_keys());
      end
      send_good(8'hF0);
      send_good(8'h23);
      vectors++;
      if ({w_key, d_key} !== 2'b10 || dut_keys() !== exp_keys()) begin
         miscompares++;
         $display("FAIL multi_release: keys=%b expected %b", dut_keys(), exp_keys());
      end
      send_good(8'hF0);
      send_good(8'h1D);
   endtask

   task automatic test_extended();
      send_good(8'hE0);
      send_good(8'h1D);
      vectors++;
      if (w_key !== 1'b0 || dut_keys() !== exp_keys()) begin
         miscompares++;
         $display("FAIL ext_ignored: keys=%b expected %b", dut_keys(), exp_keys());
      end
      send_good(8'h1C);
      vectors++;
      if (a_key !== 1'b1 || dut_keys() !== exp_keys()) begin
         miscompares++;
         $display("FAIL ext_cleared: keys=%b expected %b", dut_keys(), exp_keys());
      end
      // E0 F0 1C is an extended break: A must stay held.
      send_good(8'hE0);
      send_good(8'hF0);
      send_good(8'h1C);
      vectors++;
      if (a_key !== 1'b1 || dut_keys() !== exp_keys()) begin
         miscompares++;
         $display("FAIL ext_break_ignored: keys=%b expected %b", dut_keys(), exp_keys());
      end
   endtask

   task automatic test_bad_stop();
      int v0 = vld_cnt;
      int e0 = err_cnt;
      logic [5:0] k0 = dut_keys();
      send_frame(8'h1B, 1'b0, 1'b0);
      vectors++;
      if (err_cnt - e0 != 1 || vld_cnt != v0 || dut_keys() !== k0) begin
         miscompares++;
         $display("FAIL bad_stop: err=%0d vld=%0d keys=%b expected 1 0 %b",
                  err_cnt - e0, vld_cnt - v0, dut_keys(), k0);
      end
   endtask

   task automatic test_parity();
      int v0 = vld_cnt;
      int e0 = err_cnt;
      // 0x5A has four ones, so the odd-parity bit is 1; flipping sends parity 0.
      send_frame(8'h5A, 1'b1, 1'b1);
      if (!PAR_EN) model_byte(8'h5A);
      vectors++;
      if (err_cnt - e0 != (PAR_EN ? 1 : 0) || vld_cnt - v0 != (PAR_EN ? 0 : 1)) begin
         miscompares++;
         $display("FAIL parity_pulses: err=%0d vld=%0d expected %0d %0d",
                  err_cnt - e0, vld_cnt - v0, PAR_EN ? 1 : 0, PAR_EN ? 0 : 1);
      end
      vectors++;
      if (start_key !== !PAR_EN || dut_keys() !== exp_keys()) begin
         miscompares++;
         $display("FAIL parity_key: keys=%b expected %b", dut_keys(), exp_keys());
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         int         sel = $urandom_range(0, 9);
         logic [7:0] b;
         bit         pf  = ($urandom_range(0, 7) == 0);
         bit         sv  = ($urandom_range(0, 7) != 0);
         bit         ok;
         int         v0  = vld_cnt;
         int         e0  = err_cnt;
         case (sel)
            0: b = 8'h1D;
            1: b = 8'h1B;
            2: b = 8'h1C;
            3: b = 8'h23;
            4: b = 8'h5A;
            5: b = 8'h76;
            6: b = 8'hF0;
            7: b = 8'hE0;
            default: b = 8'($urandom_range(0, 255));
         endcase
         ok = sv && (!pf || !PAR_EN);
         send_frame(b, pf, sv);
         if (ok) model_byte(b);
         vectors++;
         if (vld_cnt - v0 != (ok ? 1 : 0) || err_cnt - e0 != (ok ? 0 : 1)) begin
            miscompares++;
            $display("FAIL random%0d_pulses: byte=%h vld=%0d err=%0d expected %0d %0d",
                     n, b, vld_cnt - v0, err_cnt - e0, ok ? 1 : 0, ok ? 0 : 1);
         end
         vectors++;
         if (dut_keys() !== exp_keys() || (ok && scan_code !== b)) begin
            miscompares++;
            $display("FAIL random%0d_state: byte=%h code=%h keys=%b expected keys %b",
                     n, b, scan_code, dut_keys(), exp_keys());
         end
      end
   endtask

   task automatic test_back_to_back();
      int v0 = vld_cnt;
      logic [7:0] seq [4];
      seq[0] = 8'h1B; seq[1] = 8'h23; seq[2] = 8'hF0; seq[3] = 8'h1B;
      for (int i = 0; i < 4; i++) begin
         ps2_bit(1'b0);
         for (int j = 0; j < 8; j++) ps2_bit(seq[i][j]);
         ps2_bit(~^seq[i]);
         ps2_bit(1'b1);
         model_byte(seq[i]);
      end
      tick(4);
      vectors++;
      if (vld_cnt - v0 != 4 || scan_code !== 8'h1B || dut_keys() !== exp_keys()) begin
         miscompares++;
         $display("FAIL back_to_back: vld=%0d code=%h keys=%b expected 4 1b %b",
                  vld_cnt - v0, scan_code, dut_keys(), exp_keys());
      end
   endtask

   task automatic test_timeout();
      int v0 = vld_cnt;
      int e0 = err_cnt;
      int n  = 0;
      logic [7:0] b = 8'h76;
      ps2_bit(1'b0);
      for (int i = 0; i < 7; i++) ps2_bit(b[i]);
      ps2_dat = b[7];
      tick(H);
      ps2_clk = 1'b0;
      while (err_cnt == e0 && n < TMO + 100) begin
         tick(1);
         n++;
         if (n == H) ps2_clk = 1'b1;
      end
      vectors++;
      if (err_cnt - e0 != 1 || vld_cnt != v0) begin
         miscompares++;
         $display("FAIL timeout_pulse: err=%0d vld=%0d expected 1 0", err_cnt - e0, vld_cnt - v0);
      end
      vectors++;
      if (n < TMO - 5 || n > TMO + 30) begin
         miscompares++;
         $display("FAIL timeout_delay: %0d cycles expected about %0d", n, TMO);
      end
      tick(4);
      send_good(8'h76);
      vectors++;
      if (restart_key !== 1'b1 || scan_code !== 8'h76 || dut_keys() !== exp_keys()) begin
         miscompares++;
         $display("FAIL timeout_recover: code=%h keys=%b expected 76 %b", scan_code, dut_keys(), exp_keys());
      end
   endtask

   task automatic test_reset_mid_frame();
      int v0, e0;
      logic [7:0] b = 8'h23;
      send_good(8'h1D);
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(b[i]);
      ps2_clk = 1'b0;
      resetn  = 1'b0;
      #1;
      vectors++;
      if (dut_keys() !== 6'b0 || scan_code !== 8'h00 || {scan_valid, frame_err} !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_mid_frame: keys=%b code=%h pulses=%b expected 0",
                  dut_keys(), scan_code, {scan_valid, frame_err});
      end
      ps2_clk = 1'b1;
      ps2_dat = 1'b1;
      model_reset();
      tick(3);
      resetn = 1'b1;
      tick(3);
      v0 = vld_cnt;
      e0 = err_cnt;
      send_good(8'h1B);
      vectors++;
      if (vld_cnt - v0 != 1 || err_cnt != e0 || scan_code !== 8'h1B || dut_keys() !== exp_keys()) begin
         miscompares++;
         $display("FAIL post_reset_frame: vld=%0d err=%0d code=%h keys=%b expected 1 0 1b %b",
                  vld_cnt - v0, err_cnt - e0, scan_code, dut_keys(), exp_keys());
      end
   endtask

   initial begin
      test_reset();
      test_single_make();
      test_make_break();
      test_multi_key();
      test_extended();
      test_bad_stop();
      test_parity();
      test_random();
      test_back_to_back();
      test_timeout();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
